// File: rtl/main_struct_fn_pkg.sv
// Shared widths and decoder line names for main_struct_fn.
// SEL_01/SEL_10 are the decoder lines whose OR forms the XOR term of F.
package main_struct_fn_pkg;

  localparam int DEC_SEL_W = 2;
  localparam int DEC_OUT_W = 4;

  localparam logic [DEC_SEL_W-1:0] SEL_01 = 2'b01;
  localparam logic [DEC_SEL_W-1:0] SEL_10 = 2'b10;

endpackage : main_struct_fn_pkg

// File: rtl/decoder_2x4_en_n.sv
// Combinational 2-to-4 decoder, active-high outputs, active-low enable.
// No state, zero latency, no flow control.
module decoder_2x4_en_n
  import main_struct_fn_pkg::*;
(
  input  logic [DEC_SEL_W-1:0] sel,
  input  logic                 en_n,
  output logic [DEC_OUT_W-1:0] y
);

  logic en;
  logic sel0_n;
  logic sel1_n;

  assign en     = ~en_n;
  assign sel0_n = ~sel[0];
  assign sel1_n = ~sel[1];

  assign y[0] = en & sel1_n & sel0_n;
  assign y[1] = en & sel1_n & sel[0];
  assign y[2] = en & sel[1] & sel0_n;
  assign y[3] = en & sel[1] & sel[0];

endmodule : decoder_2x4_en_n

// File: rtl/main_struct_fn.sv
// Registered F = (A^B)&(C|~D) built around a 2-to-4 decoder; one-cycle latency, no backpressure.
// Define MAIN_STRUCT_FN_DEC_OBS_EN to expose the registered decoder outputs on dec_y.
module main_struct_fn
  import main_struct_fn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 d,
`ifdef MAIN_STRUCT_FN_DEC_OBS_EN
  output logic [DEC_OUT_W-1:0] dec_y,
`endif
  output logic                 f
);

  logic                 d_n;
  logic                 en_or;
  logic                 en_n;
  logic [DEC_OUT_W-1:0] y;
  logic                 f_d;
  logic                 f_q;

  // Enable gating: NOT, OR, NOT gives en_n = ~c & d.
  assign d_n   = ~d;
  assign en_or = c | d_n;
  assign en_n  = ~en_or;

  decoder_2x4_en_n u_dec (
    .sel  ({a, b}),
    .en_n (en_n),
    .y    (y)
  );

  assign f_d = y[SEL_01] | y[SEL_10];

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= 1'b0;
    end else begin
      f_q <= f_d;
    end
  end

  assign f = f_q;

`ifdef MAIN_STRUCT_FN_DEC_OBS_EN
  logic [DEC_OUT_W-1:0] dec_d;
  logic [DEC_OUT_W-1:0] dec_q;

  assign dec_d = y;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= '0;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign dec_y = dec_q;
`else
  // Equal-operand lines only matter when they are observed.
  logic unused_dec;
  assign unused_dec = y[0] ^ y[3];
`endif

endmodule : main_struct_fn

// File: tb/tb_main_struct_fn.sv
// Randomized and directed bench for main_struct_fn against a truth-table reference model.
module tb_main_struct_fn;

  logic       clk;
  logic       rst;
  logic       a, b, c, d;
  logic       f;
`ifdef MAIN_STRUCT_FN_DEC_OBS_EN
  logic [3:0] dec_y;
`endif

  int n_tests;
  int n_fail;

  main_struct_fn dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
`ifdef MAIN_STRUCT_FN_DEC_OBS_EN
    .dec_y (dec_y),
`endif
    .f     (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // F is true for exactly six ABCD codes.
  function automatic logic f_model(input logic [3:0] abcd);
    int codes [6];
    logic hit;
    codes = '{4, 6, 7, 8, 10, 11};
    hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (int'(abcd) == codes[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Decoder is disabled only when C=0 and D=1; otherwise one-hot on {A,B}.
  function automatic logic [3:0] dec_model(input logic [3:0] abcd);
    logic [3:0] one;
    one = 4'b0001;
    if (abcd[1] == 1'b0 && abcd[0] == 1'b1) return 4'b0000;
    return one << abcd[3:2];
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one input set between edges, then check the registered result after the edge.
  task automatic step(input string tag, input logic [3:0] abcd, input logic r);
    logic       exp_f;
    logic [3:0] exp_dec;
    @(negedge clk);
    {a, b, c, d} = abcd;
    rst = r;
    @(posedge clk);
    #1;
    exp_f   = r ? 1'b0 : f_model(abcd);
    exp_dec = r ? 4'b0000 : dec_model(abcd);
    check($sformatf("%s f abcd=%b rst=%b", tag, abcd, r), {3'b000, f}, {3'b000, exp_f});
`ifdef MAIN_STRUCT_FN_DEC_OBS_EN
    check($sformatf("%s dec abcd=%b rst=%b", tag, abcd, r), dec_y, exp_dec);
`else
    if (exp_dec === 4'bxxxx) $display("unreachable");
`endif
  endtask

  initial begin
    logic [3:0] v;
    logic       r;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    {a, b, c, d} = 4'b0000;

    step("reset", 4'b0100, 1'b1);
    step("reset", 4'b0100, 1'b1);
    step("release", 4'b0100, 1'b0);

    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      step("sweep", v, 1'b0);
    end

    step("en_off", 4'b0101, 1'b0);
    step("en_off", 4'b1001, 1'b0);

    step("equal", 4'b0000, 1'b0);
    step("equal", 4'b0010, 1'b0);
    step("equal", 4'b1100, 1'b0);
    step("equal", 4'b1110, 1'b0);

    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? 4'b0110 : 4'b1011;
      r = (i == 4);
      step("midrst", v, r);
    end

    step("cfg", 4'b1011, 1'b0);

    for (int i = 0; i < 300; i++) begin
      v = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 15) == 0);
      step("rand", v, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_main_struct_fn

// File: doc/main_struct_fn.md
# main_struct_fn

Registered four-input boolean function block computing F = (A·B' + A'·B)·(C + D'). It is built structurally around a 2-to-4 decoder with active-high outputs and an active-low enable. It is a small leaf cell used as a structural-modelling reference and as a glue-logic qualifier wherever an XOR of two flags must be gated by a C/D condition.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- a  input  1  operand A, the decoder select MSB
- b  input  1  operand B, the decoder select LSB
- c  input  1  operand C, enable term
- d  input  1  operand D, enable term (inverted sense)
- f  output  1  registered result F
- dec_y  output  4  registered decoder outputs; present only with MAIN_STRUCT_FN_DEC_OBS_EN

One clock. Reset is synchronous and active-high.

## Operation
- Active-low enable: en_n = ~(c | ~d) = ~c & d.
- Decoder select is {a,b}.
- When en_n = 0, decoder output y[{a,b}] = 1 and every other bit = 0.
- When en_n = 1, y = 4'b0000.
- The function output is the OR of the XOR terms: f_next = y[1] | y[2] (select 01 or 10).
- Equivalent form: f_next = (a ^ b) & (c | ~d).
- F = 1 exactly for ABCD = 0100, 0110, 0111, 1000, 1010 and 1011; all other codes give 0.
- No handshake. Inputs are sampled every cycle, and the block has no internal state beyond the output registers.
- X or Z on the inputs is not specified; the bench drives only 0/1.

## Timing
- Latency: f reflects the inputs sampled at rising edge N, starting from edge N.
- The result holds until the next edge. Throughput is one evaluation per cycle.
- Reset: while rst = 1 at a rising edge, f <= 0 and dec_y <= 4'b0000, regardless of the inputs.
- Reset dominates any input value. On the first edge with rst = 0, f takes the function of the inputs sampled at that edge.
- Reset asserted mid-stream clears the outputs on that edge. No stale value survives.
- Inputs changing between edges have no effect on f until the next edge. The output is glitch-free.

## Configuration
- MAIN_STRUCT_FN_DEC_OBS_EN defined:
  - the dec_y[3:0] port exists and is registered alongside f;
  - dec_y has the same latency and reset value 0.
- Not defined:
  - the port is absent and the decoder outputs are internal only;
  - f behaviour is identical in both builds.

## Structure
- Shared package main_struct_fn_pkg holds:
  - DEC_SEL_W = 2 and DEC_OUT_W = 4;
  - localparams SEL_01 = 2'b01 and SEL_10 = 2'b10, naming the decoder lines ORed into F.
- One sub-module, decoder_2x4_en_n:
  - inputs: sel[1:0] and en_n;
  - output: y[3:0], purely combinational, built from gate primitives / continuous assigns;
  - it is instantiated once in main_struct_fn.
- The top level holds the enable gating (NOT/OR/NOT), the output OR, and the clk/rst output registers.

## Test plan
- Reset: hold rst = 1 for 2 cycles with ABCD = 0100 -> f = 0 (and dec_y = 0000); release rst -> f = 1 at the next edge.
- Exhaustive sweep: ABCD = 0000 through 1111, one per cycle -> f = 1 only for 4, 6, 7, 8, 10 and 11, each one cycle after the input is applied.
- Enable off: ABCD = 0101 and 1001 (C = 0, D = 1) -> f = 0 and dec_y = 0000.
- Equal operands: ABCD = 0000, 0010, 1100 and 1110 -> f = 0; dec_y = 0001, 0001, 1000 and 1000 respectively.
- Mid-stream reset: toggle ABCD between 0110 and 1011 every cycle, pulse rst for 1 cycle -> f = 0 on exactly that edge, then 1 again on the following edge.
- Config build with MAIN_STRUCT_FN_DEC_OBS_EN, ABCD = 1011 -> dec_y = 0100 and f = 1.
